mem_bus_arbiter: RTL and testbench

- Shares one unified instruction/data memory between three requesters.
- Requesters: instruction fetch (FETCH state), load/store (MEMORY state, driven by MemRead/MemWrite), and an external program-loader/debug port.
- Serialises accesses with a req/ack handshake, tolerates variable memory latency, and guarantees the loader cannot starve.
- Sits between Control_Unit/datapath and the memory block.

---
 rtl/mem_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises fetch, load/store and loader/debug accesses onto
// one shared instruction/data memory using a req/ack handshake. The memory may
// take a variable number of cycles; a stalled access is closed with an error
// response. A starvation counter lets the loader win eventually.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner, arbitrate on the next edge with any request high
// BUSY    | mem_en high, waiting for mem_ready or the timeout
// RESP    | one-cycle ack to the owner, rdata/err valid
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  if_ack,
    output logic                  ls_ack,
    output logic                  ext_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy,
    output logic [1:0]            grant_id,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] GID_IF   = 2'd0;
    localparam logic [1:0] GID_LS   = 2'd1;
    localparam logic [1:0] GID_EXT  = 2'd2;
    localparam logic [1:0] GID_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   tmo_cnt;
    logic [SW-1:0]   starve_cnt;
    logic [1:0]      win_id;
    logic            any_req;
    logic            tmo_hit;
    logic            starved;

    // Winner of the next arbitration: a starved loader first, then ls > if > ext
    always_comb begin
        any_req = if_req | ls_req | ext_req;
        starved = ext_req && (starve_cnt == SW'(STARVE_LIMIT));
        tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
        if (starved)
            win_id = GID_EXT;
        else if (ls_req)
            win_id = GID_LS;
        else if (if_req)
            win_id = GID_IF;
        else if (ext_req)
            win_id = GID_EXT;
        else
            win_id = GID_NONE;
    end

    // Arbitration FSM with registered memory strobes and requester responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
            ext_ack    <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= GID_NONE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state    <= ST_BUSY;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        grant_id <= win_id;
                        tmo_cnt  <= '0;
                        case (win_id)
                            GID_LS: begin
                                mem_we    <= ls_we;
                                mem_addr  <= ls_addr;
                                mem_wdata <= ls_wdata;
                            end
                            GID_IF: begin
                                mem_we    <= 1'b0;
                                mem_addr  <= if_addr;
                                mem_wdata <= '0;
                            end
                            default: begin
                                mem_we    <= ext_we;
                                mem_addr  <= ext_addr;
                                mem_wdata <= ext_wdata;
                            end
                        endcase
                        // Loader losses are only counted while it is asking
                        if (win_id == GID_EXT)
                            starve_cnt <= '0;
                        else if (ext_req && !starved)
                            starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                ST_BUSY: begin
                    // mem_ready takes precedence over a simultaneous timeout
                    if (mem_ready || tmo_hit) begin
                        state   <= ST_RESP;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        if_ack  <= (grant_id == GID_IF);
                        ls_ack  <= (grant_id == GID_LS);
                        ext_ack <= (grant_id == GID_EXT);
                        err     <= !mem_ready;
                        rdata   <= (mem_ready && !mem_we) ? mem_rdata : '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    if_ack   <= 1'b0;
                    ls_ack   <= 1'b0;
                    ext_ack  <= 1'b0;
                    err      <= 1'b0;
                    busy     <= 1'b0;
                    grant_id <= GID_NONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by a randomized run.
// Expected owners come from the arbitration rules applied to the set of
// pending requests; read data comes from a simple memory array.
module tb_mem_bus_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int TMO  = 15;
    localparam int SLIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0, ls_req = 1'b0, ext_req = 1'b0;
    logic          ls_we = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] if_addr = '0, ls_addr = '0, ext_addr = '0;
    logic [DW-1:0] ls_wdata = '0, ext_wdata = '0;
    logic          if_ack, ls_ack, ext_ack, err, busy;
    logic [DW-1:0] rdata;
    logic [1:0]    grant_id;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0] mem_model [0:4095];
    bit            pend    [3];
    logic [AW-1:0] p_addr  [3];
    logic          p_we    [3];
    logic [DW-1:0] p_wdata [3];
    int            starve_ref = 0;

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .if_ack(if_ack), .ls_ack(ls_ack), .ext_ack(ext_ack),
        .rdata(rdata), .err(err), .busy(busy), .grant_id(grant_id),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        if_req    = pend[0];
        if_addr   = p_addr[0];
        ls_req    = pend[1];
        ls_we     = p_we[1];
        ls_addr   = p_addr[1];
        ls_wdata  = p_wdata[1];
        ext_req   = pend[2];
        ext_we    = p_we[2];
        ext_addr  = p_addr[2];
        ext_wdata = p_wdata[2];
    endtask

    task automatic set_req(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        pend[id]    = 1'b1;
        p_addr[id]  = a;
        p_we[id]    = (id == 0) ? 1'b0 : we;
        p_wdata[id] = (id == 0) ? '0 : wd;
    endtask

    // Owner chosen from pending requests: starved loader, else ls, if, ext
    function automatic int ref_winner();
        if (pend[2] && starve_ref == SLIM) return 2;
        if (pend[1]) return 1;
        if (pend[0]) return 0;
        return 2;
    endfunction

    // One access from the arbitration edge to the return to idle.
    // d = number of wait cycles before mem_ready (d >= TMO never answers).
    task automatic run_one(input int d, input bit drop_mid,
                           output int entry_cyc, output int ack_cyc,
                           output int gid, output logic [DW-1:0] rd);
        int            w;
        int            c;
        int            exp_c;
        bit            got;
        bit            exp_err;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ewd;
        logic [DW-1:0] exp_rd;

        w   = ref_winner();
        ea  = p_addr[w];
        ewe = p_we[w];
        ewd = p_wdata[w];
        exp_rd = mem_model[ea];
        if (w == 2) starve_ref = 0;
        else if (pend[2] && starve_ref < SLIM) starve_ref++;
        exp_c   = (d < TMO) ? d : TMO - 1;
        exp_err = (d >= TMO);

        @(negedge clk);
        entry_cyc = cyc;
        gid = w;
        chk("grant_id", {30'd0, grant_id}, w[DW-1:0]);
        chk("busy_on", {31'd0, busy}, 32'd1);

        c = 0;
        got = 1'b0;
        while (!got && c < 40) begin
            chk("mem_en_busy", {31'd0, mem_en}, 32'd1);
            chk("mem_addr", {20'd0, mem_addr}, {20'd0, ea});
            chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
            chk("mem_wdata", mem_wdata, ewd);
            if (drop_mid && c == 0) pend[w] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!pend[i]) begin
                    p_addr[i]  = AW'($urandom);
                    p_wdata[i] = $urandom;
                    p_we[i]    = (i == 0) ? 1'b0 : 1'($urandom);
                end
            end
            drive_reqs();
            if (c == d) begin
                mem_ready = 1'b1;
                mem_rdata = mem_model[mem_addr];
                if (mem_we) mem_model[mem_addr] = mem_wdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            if (if_ack || ls_ack || ext_ack) got = 1'b1;
            else c++;
        end

        ack_cyc = cyc;
        rd = rdata;
        chk("ack_seen", {31'd0, got}, 32'd1);
        chk("ack_wait", c[DW-1:0], exp_c[DW-1:0]);
        chk("if_ack", {31'd0, if_ack}, {31'd0, w == 0});
        chk("ls_ack", {31'd0, ls_ack}, {31'd0, w == 1});
        chk("ext_ack", {31'd0, ext_ack}, {31'd0, w == 2});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("rdata", rdata, (exp_err || ewe) ? '0 : exp_rd);
        chk("mem_en_resp", {31'd0, mem_en}, 32'd0);
        chk("busy_resp", {31'd0, busy}, 32'd1);

        pend[w] = 1'b0;
        drive_reqs();
        @(negedge clk);
        chk("acks_idle", {29'd0, if_ack, ls_ack, ext_ack}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("grant_idle", {30'd0, grant_id}, 32'd3);
        chk("err_idle", {31'd0, err}, 32'd0);
    endtask

    initial begin
        int e0, a0, e1, a1, g0, g1, d;
        int gseq [6];
        logic [DW-1:0] r0, r1;

        for (int i = 0; i < 4096; i++) mem_model[i] = $urandom;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; p_addr[i] = '0; p_we[i] = 1'b0; p_wdata[i] = '0;
        end
        drive_reqs();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_acks", {29'd0, if_ack, ls_ack, ext_ack}, 32'd0);
        chk("rst_err_busy", {30'd0, err, busy}, 32'd0);
        chk("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd3);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single fetch, memory answers in the third busy cycle
        mem_model[12'h010] = 32'hDEADBEEF;
        set_req(0, 1'b0, 12'h010, '0);
        drive_reqs();
        run_one(2, 1'b0, e0, a0, g0, r0);
        chk("t1_latency", a0 - e0, 32'd3);
        chk("t1_rdata", r0, 32'hDEADBEEF);

        // ls and if together: ls first, if follows 3 cycles later
        set_req(0, 1'b0, 12'h030, '0);
        set_req(1, 1'b1, 12'h020, 32'h12345678);
        drive_reqs();
        run_one(0, 1'b0, e0, a0, g0, r0);
        run_one(0, 1'b0, e1, a1, g1, r1);
        chk("t2_first", g0, 32'd1);
        chk("t2_second", g1, 32'd0);
        chk("t2_spacing", a1 - a0, 32'd3);
        chk("t2_stored", mem_model[12'h020], 32'h12345678);

        // loader starvation: four ls wins, then ext, then ls again
        set_req(2, 1'b0, 12'h040, '0);
        for (int k = 0; k < 6; k++) begin
            if (!pend[2]) set_req(2, 1'b0, 12'h041, '0);
            set_req(1, 1'b0, AW'(12'h050 + k), '0);
            drive_reqs();
            run_one(0, 1'b0, e0, a0, gseq[k], r0);
        end
        chk("t3_g0", gseq[0], 32'd1);
        chk("t3_g3", gseq[3], 32'd1);
        chk("t3_g4_ext", gseq[4], 32'd2);
        chk("t3_g5_cleared", gseq[5], 32'd1);
        run_one(1, 1'b0, e0, a0, g0, r0);
        chk("t3_drain", g0, 32'd2);

        // ls load with no memory answer: timeout error
        set_req(1, 1'b0, 12'h060, '0);
        drive_reqs();
        run_one(99, 1'b0, e0, a0, g0, r0);
        chk("t4_len", a0 - e0, 32'd15);
        chk("t4_rdata", r0, 32'd0);

        // mem_ready on the same edge as the timeout: ready wins
        set_req(0, 1'b0, 12'h061, '0);
        drive_reqs();
        run_one(TMO - 1, 1'b0, e0, a0, g0, r0);

        // reset one cycle into busy
        set_req(0, 1'b0, 12'h123, '0);
        drive_reqs();
        @(negedge clk);
        chk("t5_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_mem_en", {31'd0, mem_en}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_acks", {29'd0, if_ack, ls_ack, ext_ack}, 32'd0);
        chk("t5_grant", {30'd0, grant_id}, 32'd3);
        pend[0] = 1'b0;
        drive_reqs();
        starve_ref = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_ack", {29'd0, if_ack, ls_ack, ext_ack}, 32'd0);
            chk("t5_idle", {31'd0, busy}, 32'd0);
        end
        set_req(0, 1'b0, 12'h124, '0);
        drive_reqs();
        run_one(1, 1'b0, e0, a0, g0, r0);
        chk("t5_after", g0, 32'd0);

        // loader write, then fetch of the same word
        set_req(2, 1'b1, 12'h7FF, 32'hCAFEF00D);
        drive_reqs();
        run_one(1, 1'b0, e0, a0, g0, r0);
        chk("t6_ext", g0, 32'd2);
        set_req(0, 1'b0, 12'h7FF, '0);
        drive_reqs();
        run_one(0, 1'b0, e0, a0, g0, r0);
        chk("t6_if", g0, 32'd0);
        chk("t6_rdata", r0, 32'hCAFEF00D);

        // randomized mix of requesters, latencies and mid-access drops
        repeat (80) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom),
                            ($urandom_range(0, 7) == 0) ? 12'h7FF : AW'($urandom_range(0, 15)),
                            $urandom);
            end
            if (!pend[0] && !pend[1] && !pend[2]) begin
                drive_reqs();
                @(negedge clk);
                chk("rnd_idle_busy", {31'd0, busy}, 32'd0);
                chk("rnd_idle_grant", {30'd0, grant_id}, 32'd3);
                set_req($urandom_range(0, 2), 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
            end
            drive_reqs();
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: d = $urandom_range(0, 2);
                6, 7:             d = $urandom_range(3, 6);
                8:                d = TMO - 1;
                default:          d = TMO + $urandom_range(0, 3);
            endcase
            run_one(d, ($urandom_range(0, 5) == 0), e0, a0, g0, r0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
